// File: rtl/pulse_period_meter_if.sv
// Bundles the pulse-train input, enable and measurement results of pulse_period_meter.
// The master modport belongs to the agent driving pulses. The slave modport belongs to the meter.
interface pulse_period_meter_if #(
    parameter int N = 8
);
    logic         ena;
    logic         in;
    logic [N-1:0] period;
    logic         valid;
    logic         overflow;

    modport master (
        output ena,
        output in,
        input  period,
        input  valid,
        input  overflow
    );

    modport slave (
        input  ena,
        input  in,
        output period,
        output valid,
        output overflow
    );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures rising-edge spacing of bus.in in cycles. Result and one-cycle valid come one cycle after the closing edge.
// No backpressure: a result is overwritten by the next one, and long gaps raise a sticky overflow.
module pulse_period_meter #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_period_meter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        OVF  = 2'd2
    } state_t;

    localparam logic [N-1:0] CNT_MAX = '1;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] cnt;
    logic [N-1:0] cnt_nxt;
    logic [N-1:0] period_q;
    logic [N-1:0] period_nxt;
    logic         valid_q;
    logic         valid_nxt;
    logic         ovf_q;
    logic         ovf_nxt;
    logic         in_d;
    logic         edge_det;

    // in_d tracks the input even while disabled, so a level held across re-enable is not a new edge
    assign edge_det = bus.in & ~in_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            in_d     <= 1'b0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            in_d     <= bus.in;
            period_q <= period_nxt;
            valid_q  <= valid_nxt;
            ovf_q    <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period_q;
        valid_nxt  = 1'b0;
        ovf_nxt    = ovf_q;

        if (!bus.ena) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (edge_det) begin
                        cnt_nxt   = {{(N-1){1'b0}}, 1'b1};
                        state_nxt = MEAS;
                    end
                end
                MEAS: begin
                    // an edge landing on the saturated count is still a valid period of CNT_MAX
                    if (edge_det) begin
                        period_nxt = cnt;
                        valid_nxt  = 1'b1;
                        ovf_nxt    = 1'b0;
                        cnt_nxt    = {{(N-1){1'b0}}, 1'b1};
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        ovf_nxt   = 1'b1;
                        state_nxt = OVF;
                    end
                end
                OVF: begin
                    if (edge_det) begin
                        cnt_nxt   = {{(N-1){1'b0}}, 1'b1};
                        state_nxt = MEAS;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign bus.period   = period_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = ovf_q;
endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the spacing, in clock cycles, between rising edges of a single-bit pulse train. It is the receive-side counterpart to the pulse generator. It sits downstream of any periodic tick source and reports each measured period with a one-cycle valid strobe. Periods too long for the counter are reported as overflow instead of as a wrapped value.

## Interface
- `N`, default 8: width of the period counter and of the `period` output. The largest measurable period is 2^N-1.
- `clk`, input, 1: sole clock; everything is on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset (block is held in reset while 0).
- `ena`, input, 1: measurement enable.
- `in`, input, 1: pulse train, synchronous to `clk`.
- `period`, output, N: last measured edge-to-edge spacing in cycles.
- `valid`, output, 1: high for exactly one cycle when `period` has just been updated.
- `overflow`, output, 1: sticky flag meaning the spacing exceeded 2^N-1.

## Operation
- Edge detect:
  - `in_d` is a register sampling `in` every cycle, including while `ena`=0.
  - `edge` = `in` & ~`in_d`, combinational.
  - A multi-cycle high level counts as one edge. A constantly high input produces exactly one edge.
- Counter `cnt` (N bits) saturates at 2^N-1 and never wraps.
- FSM states and transitions:
  - IDLE: waiting for the first edge. On `edge` & `ena`: `cnt`<=1, go to MEAS. No `valid`.
  - MEAS, on `edge`: `period`<=`cnt`, `valid`<=1, `overflow`<=0, `cnt`<=1, stay in MEAS.
  - MEAS, with no `edge` and `cnt`<2^N-1: `cnt`<=`cnt`+1.
  - MEAS, with no `edge` and `cnt`==2^N-1: `overflow`<=1, go to OVF. `period` is unchanged.
  - OVF: on `edge`: `cnt`<=1, go to MEAS. No `valid`. `overflow` stays 1.
- Simultaneous edge and saturation: an edge in the cycle where `cnt`==2^N-1 is a valid measurement with `period`=2^N-1. It does not overflow.
- `ena`=0:
  - FSM goes to IDLE on the next clock and `cnt`<=0.
  - `valid`<=0.
  - `period` and `overflow` hold their values.
  - Edges seen while disabled are discarded.
- Reset values:
  - state = IDLE
  - `cnt`=0
  - `in_d`=0
  - `period`=0
  - `valid`=0
  - `overflow`=0
- Arithmetic: unsigned. `period` is the cycle distance t1−t0 between the two edge cycles. A pulse every P clocks therefore measures as P.

## Timing
- Latency: `valid` and the new `period` appear in the cycle immediately after the clock edge at which the second `edge` is sampled. That is one cycle after `in` rises.
- `valid` is never high on two consecutive cycles, because consecutive edges need at least one low cycle in between. The minimum reported period is 2.
- The first edge after reset, after `ena` rises, or after OVF never produces `valid`. The first `valid` follows the second edge.
- `overflow` rises one cycle after the cycle in which `cnt` sat at 2^N-1 with no edge. It falls together with the next `valid`.
- Reset asserted mid-measurement: all outputs go to their reset values immediately (asynchronously).
  - After `rst` rises, an `in` that is already high counts as an edge, because `in_d`=0.
- `ena` falling in the same cycle as an edge: the disable wins, so there is no `valid` and the FSM goes to IDLE.

## Test plan
- Periodic train, N=8: 1-cycle pulses every 5 clocks for 6 pulses. Expect `valid` after pulses 2–6, each time with `period`=5; `overflow`=0 throughout.
- Minimum spacing and level input: alternate `in` 1,0,1,0,… Expect `period`=2 on every `valid`. Then hold `in` high for 10 cycles. Expect no further `valid`.
- Saturation boundary, N=4:
  - Spacing 15: `valid` with `period`=15, `overflow`=0.
  - Spacing 16: `overflow`=1 with no `valid`, and `period` still holds 15.
  - Follow with spacings 16 and 7. Expect `valid` with `period`=7 and `overflow` cleared in the same cycle.
- Enable gating: run spacing 6, deassert `ena` for 20 cycles while pulses continue, then reassert. Expect no `valid` while disabled, `period` holding 6, and the first `valid` only at the second edge after re-enable.
- Asynchronous reset mid-count: after `period`=9 is reported, pull `rst` low between edges. Expect `period`=0, `valid`=0, `overflow`=0 immediately. After release, expect two edges before the next `valid`.
